// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: fetch-ahead queue between core IF/ID and fixed-latency instruction memory
// Ports: clk/rst_n (sync, active low); redirect_i/redirect_pc_i flush and restart fetch;
// instr_valid_o/instr_ready_i/instr_o/instr_pc_o head handshake to the core;
// im_addr_o/im_oen_o/im_rdata_i memory read port; occupancy_o buffered entry count.
module ifetch_prefetch_queue #(
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 1,
   parameter int AW      = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     redirect_i,
   input  logic [AW-1:0]            redirect_pc_i,
   input  logic                     instr_ready_i,
   output logic                     instr_valid_o,
   output logic [31:0]              instr_o,
   output logic [AW-1:0]            instr_pc_o,
   output logic [AW-1:0]            im_addr_o,
   output logic                     im_oen_o,
   input  logic [31:0]              im_rdata_i,
   output logic [$clog2(DEPTH):0]   occupancy_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;
   localparam int CW = PW + 2;
   localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
   logic            started_q;
   logic [AW-1:0]   pc_q, pc_d;
   logic [MEM_LAT-1:0] fv_q, fv_d;
   logic [AW-1:0]   fpc_q [MEM_LAT];
   logic [AW-1:0]   fpc_d [MEM_LAT];
   logic [31:0]     data_q [DEPTH];
   logic [AW-1:0]   dpc_q [DEPTH];
   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [OW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   credit;
   logic            issue, push, pop;
   // every in-flight request holds a reserved FIFO entry, so pushes never overflow
   always_comb begin
      credit = CW'(cnt_q);
      for (int i = 0; i < MEM_LAT; i++) credit = credit + CW'(fv_q[i]);
      issue = started_q && credit < DEPTH_W;
      push = fv_q[MEM_LAT-1] && !redirect_i;
      pop = instr_valid_o && instr_ready_i && !redirect_i;
      pc_d = redirect_i ? redirect_pc_i : pc_q + AW'(issue);
      fv_d[0] = issue && !redirect_i;
      fpc_d[0] = pc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
         fv_d[i] = fv_q[i-1] && !redirect_i;
         fpc_d[i] = fpc_q[i-1];
      end
      rd_d = redirect_i ? '0 : rd_q + PW'(pop);
      wr_d = redirect_i ? '0 : wr_q + PW'(push);
      cnt_d = redirect_i ? '0 : cnt_q + OW'(push) - OW'(pop);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         started_q <= 1'b0;
         pc_q <= '0;
         fv_q <= '0;
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         started_q <= 1'b1;
         pc_q <= pc_d;
         fv_q <= fv_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
      end
   end
   // payload storage needs no reset: the valid bits and count gate every use
   always_ff @(posedge clk) begin
      fpc_q <= fpc_d;
      if (push) begin
         data_q[wr_q] <= im_rdata_i;
         dpc_q[wr_q] <= fpc_q[MEM_LAT-1];
      end
   end
   assign instr_valid_o = cnt_q != '0;
   assign instr_o = instr_valid_o ? data_q[rd_q] : '0;
   assign instr_pc_o = instr_valid_o ? dpc_q[rd_q] : '0;
   assign im_addr_o = pc_q;
   assign im_oen_o = !issue;
   assign occupancy_o = cnt_q;
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue: scoreboard bench for the instruction prefetch queue
module tb_ifetch_prefetch_queue;
   localparam int DEPTH = 4;
   localparam int MEM_LAT = 2;
   localparam int AW = 11;
   localparam int OW = $clog2(DEPTH) + 1;
   logic clk, rst_n, redirect_i, instr_ready_i, instr_valid_o, im_oen_o;
   logic [AW-1:0] redirect_pc_i, instr_pc_o, im_addr_o;
   logic [31:0] instr_o, im_rdata_i;
   logic [OW-1:0] occupancy_o;
   int checks = 0, errors = 0, deliveries = 0;
   bit mon_en = 0;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_next;
   logic [AW-1:0] pa [MEM_LAT];
   logic [MEM_LAT-1:0] pv;

   ifetch_prefetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .instr_ready_i(instr_ready_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
      .instr_pc_o(instr_pc_o), .im_addr_o(im_addr_o), .im_oen_o(im_oen_o),
      .im_rdata_i(im_rdata_i), .occupancy_o(occupancy_o));

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [AW-1:0] a);
      return 32'h1000_0000 + 32'(a);
   endfunction

   always @(posedge clk) begin
      pa[0] <= im_addr_o;
      pv[0] <= !im_oen_o;
      for (int i = 1; i < MEM_LAT; i++) begin
         pa[i] <= pa[i-1];
         pv[i] <= pv[i-1];
      end
   end
   assign im_rdata_i = pv[MEM_LAT-1] ? word(pa[MEM_LAT-1]) : 32'hDEAD_BEEF;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic void refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_next);
         exp_next = exp_next + 1'b1;
      end
   endfunction

   function automatic void model_restart(input logic [AW-1:0] t);
      exp_q.delete();
      exp_next = t;
      refill();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [AW-1:0] t);
      redirect_i = 1;
      redirect_pc_i = t;
      model_restart(t);
      tick();
      redirect_i = 0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid_vs_occ", 32'(instr_valid_o), 32'(occupancy_o != 0));
         chk("occ_bound", 32'(occupancy_o <= DEPTH), 1);
         if (!instr_valid_o) chk("bubble", {instr_o[31:AW], instr_o[AW-1:0] | instr_pc_o}, 0);
         if (occupancy_o == OW'(DEPTH)) chk("no_issue_full", 32'(im_oen_o), 1);
         if (rst_n && !redirect_i && instr_valid_o && instr_ready_i && exp_q.size() > 0) begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", 32'(instr_pc_o), 32'(e));
            chk("sb_instr", instr_o, word(e));
            deliveries++;
            refill();
         end
      end
   end

   initial begin
      int run, d0, r;
      rst_n = 0; redirect_i = 0; redirect_pc_i = '0; instr_ready_i = 1;
      model_restart('0);
      tick();
      mon_en = 1;
      chk("rst_valid", 32'(instr_valid_o), 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", 32'(instr_pc_o), 0);
      chk("rst_oen", 32'(im_oen_o), 1);
      chk("rst_addr", 32'(im_addr_o), 0);
      chk("rst_occ", 32'(occupancy_o), 0);
      rst_n = 1;
      tick();
      chk("start_oen", 32'(im_oen_o), 0);
      for (int k = 0; k <= MEM_LAT; k++) begin
         chk("addr_step", 32'(im_addr_o), k);
         chk("no_early_valid", 32'(instr_valid_o), 0);
         tick();
      end
      chk("first_valid", 32'(instr_valid_o), 1);
      chk("first_pc", 32'(instr_pc_o), 0);
      chk("first_instr", instr_o, 32'h1000_0000);
      repeat (5) tick();
      instr_ready_i = 0;
      do_redirect(11'h020);
      repeat (10) tick();
      chk("bp_occ", 32'(occupancy_o), DEPTH);
      chk("bp_oen", 32'(im_oen_o), 1);
      chk("bp_head", 32'(instr_pc_o), 32'h20);
      chk("bp_instr", instr_o, word(11'h020));
      instr_ready_i = 1;
      tick();
      instr_ready_i = 0;
      chk("pop_head", 32'(instr_pc_o), 32'h21);
      chk("pop_occ", 32'(occupancy_o), DEPTH - 1);
      chk("pop_oen", 32'(im_oen_o), 0);
      chk("pop_addr", 32'(im_addr_o), 32'h20 + DEPTH);
      tick();
      chk("one_issue", 32'(im_oen_o), 1);
      repeat (5) tick();
      chk("refull_occ", 32'(occupancy_o), DEPTH);
      instr_ready_i = 1;
      do_redirect(11'h300);
      chk("flush_occ", 32'(occupancy_o), 0);
      chk("flush_addr", 32'(im_addr_o), 32'h300);
      repeat (8) tick();
      do_redirect(11'h100);
      chk("redir_addr", 32'(im_addr_o), 32'h100);
      for (int k = 0; k <= MEM_LAT; k++) begin
         chk("redir_bubble", 32'(instr_valid_o), 0);
         tick();
      end
      chk("redir_valid", 32'(instr_valid_o), 1);
      chk("redir_pc", 32'(instr_pc_o), 32'h100);
      repeat (4) tick();
      do_redirect(11'h7FE);
      repeat (MEM_LAT + 1) tick();
      for (int k = 0; k < 4; k++) begin
         logic [AW-1:0] e;
         e = AW'(32'h7FE + k);
         chk("wrap_pc", 32'(instr_pc_o), 32'(e));
         chk("wrap_instr", instr_o, word(e));
         tick();
      end
      rst_n = 0; redirect_i = 1; redirect_pc_i = 11'h055;
      model_restart('0);
      tick();
      redirect_i = 0;
      chk("rst_redir_addr", 32'(im_addr_o), 0);
      chk("rst_redir_occ", 32'(occupancy_o), 0);
      rst_n = 1;
      tick();
      chk("rst_redir_restart", 32'(im_addr_o), 0);
      repeat (10) tick();
      run = 0;
      for (int k = 0; k < 50; k++) begin
         if (instr_valid_o) run++;
         tick();
      end
      chk("throughput", run, 50);
      d0 = deliveries;
      for (int c = 0; c < 3000; c++) begin
         instr_ready_i = $urandom_range(0, 9) < 7;
         r = $urandom_range(0, 199);
         if (r < 6) begin
            redirect_i = 1;
            redirect_pc_i = AW'($urandom);
         end
         if (r == 199) rst_n = 0;
         if (!rst_n) model_restart('0);
         else if (redirect_i) model_restart(redirect_pc_i);
         tick();
         redirect_i = 0;
         rst_n = 1;
      end
      chk("random_progress", 32'(deliveries - d0 > 1000), 1);
      instr_ready_i = 1;
      repeat (10) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
